// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: free-running column/row raster with eight
// selectable colour patterns, raw active-area syncs and a frame-start pulse.
// Every output is registered from the current counter values (1-cycle latency).
module vga_pattern_gen #(
    parameter int unsigned VIDEO_WIDTH = 3,
    parameter int unsigned TOTAL_COLS  = 800,
    parameter int unsigned TOTAL_ROWS  = 525,
    parameter int unsigned ACTIVE_COLS = 640,
    parameter int unsigned ACTIVE_ROWS = 480
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic [2:0]             i_Pattern,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic [VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic                   o_Frame_Start
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned CMP_W = CNT_W + 1;
    localparam int unsigned BAR_W = ACTIVE_COLS / 8;

    localparam logic [CNT_W-1:0] LAST_COL     = CNT_W'(TOTAL_COLS - 1);
    localparam logic [CNT_W-1:0] LAST_ROW     = CNT_W'(TOTAL_ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_ACT_COL = CNT_W'(ACTIVE_COLS - 1);
    localparam logic [CNT_W-1:0] LAST_ACT_ROW = CNT_W'(ACTIVE_ROWS - 1);
    // One extra bit so an active size of 1024 still compares correctly
    localparam logic [CMP_W-1:0] ACT_COLS_W   = CMP_W'(ACTIVE_COLS);
    localparam logic [CMP_W-1:0] ACT_ROWS_W   = CMP_W'(ACTIVE_ROWS);
    localparam logic [VIDEO_WIDTH-1:0] FULL   = {VIDEO_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        PAT_BLACK   = 3'd0,
        PAT_RED     = 3'd1,
        PAT_GREEN   = 3'd2,
        PAT_BLUE    = 3'd3,
        PAT_CHECKER = 3'd4,
        PAT_BARS    = 3'd5,
        PAT_BORDER  = 3'd6,
        PAT_GRAD    = 3'd7
    } pattern_e;

    logic [CNT_W-1:0]       col_q, col_d;
    logic [CNT_W-1:0]       row_q, row_d;
    pattern_e               pat_q, pat_d;
    logic                   hsync_q, hsync_d;
    logic                   vsync_q, vsync_d;
    logic                   frame_start_q, frame_start_d;
    logic [VIDEO_WIDTH-1:0] red_q, red_d;
    logic [VIDEO_WIDTH-1:0] grn_q, grn_d;
    logic [VIDEO_WIDTH-1:0] blu_q, blu_d;
    logic [2:0]             bar_c;
    logic                   border_c;
    logic [VIDEO_WIDTH-1:0] grad_c;

    // Raster advance; the pattern is latched only on the last pixel of a frame
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        pat_d = pat_q;
        if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
                row_d = '0;
                pat_d = pattern_e'(i_Pattern);
            end else begin
                row_d = row_q + 10'd1;
            end
        end else begin
            col_d = col_q + 10'd1;
        end
    end

    // Colour-bar index by threshold comparison against constant bar edges
    always_comb begin
        bar_c = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if ({1'b0, col_q} >= CMP_W'(i * BAR_W)) begin
                bar_c = bar_c + 3'd1;
            end
        end
    end

    // Border hit and horizontal gradient level
    always_comb begin
        border_c = (col_q == '0) || (col_q == LAST_ACT_COL) ||
                   (row_q == '0) || (row_q == LAST_ACT_ROW);
        grad_c   = col_q[CNT_W-1 -: VIDEO_WIDTH];
    end

    // Next output values for the pixel currently held in the counters
    always_comb begin
        hsync_d       = ({1'b0, col_q} < ACT_COLS_W);
        vsync_d       = ({1'b0, row_q} < ACT_ROWS_W);
        frame_start_d = (col_q == '0) && (row_q == '0);
        red_d         = '0;
        grn_d         = '0;
        blu_d         = '0;
        if (hsync_d && vsync_d) begin
            case (pat_q)
                PAT_BLACK: begin
                end
                PAT_RED:   red_d = FULL;
                PAT_GREEN: grn_d = FULL;
                PAT_BLUE:  blu_d = FULL;
                PAT_CHECKER: begin
                    if (col_q[5] ^ row_q[5]) begin
                        red_d = FULL;
                        grn_d = FULL;
                        blu_d = FULL;
                    end
                end
                PAT_BARS: begin
                    red_d = bar_c[2] ? FULL : '0;
                    grn_d = bar_c[1] ? FULL : '0;
                    blu_d = bar_c[0] ? FULL : '0;
                end
                PAT_BORDER: begin
                    if (border_c) begin
                        red_d = FULL;
                        grn_d = FULL;
                        blu_d = FULL;
                    end
                end
                PAT_GRAD: begin
                    red_d = grad_c;
                    grn_d = grad_c;
                    blu_d = grad_c;
                end
            endcase
        end
    end

    // State and output registers; reset clears everything asynchronously
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            col_q         <= '0;
            row_q         <= '0;
            pat_q         <= PAT_BLACK;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
            red_q         <= '0;
            grn_q         <= '0;
            blu_q         <= '0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            pat_q         <= pat_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            red_q         <= red_d;
            grn_q         <= grn_d;
            blu_q         <= blu_d;
        end
    end

    assign o_HSync       = hsync_q;
    assign o_VSync       = vsync_q;
    assign o_Frame_Start = frame_start_q;
    assign o_Red_Video   = red_q;
    assign o_Grn_Video   = grn_q;
    assign o_Blu_Video   = blu_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen on a reduced raster (100x40, 80x36 active, 6-bit colour).
module tb_vga_pattern_gen;

    localparam int VW = 6;
    localparam int TC = 100;
    localparam int TR = 40;
    localparam int AC = 80;
    localparam int AR = 36;
    localparam int F  = TC * TR;
    localparam logic [VW-1:0] FULL = {VW{1'b1}};

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          fs;
        logic [VW-1:0] r;
        logic [VW-1:0] g;
        logic [VW-1:0] b;
    } pix_t;

    typedef struct {
        logic [2:0]    pat;
        int            col;
        int            row;
        logic          hs;
        logic          vs;
        logic [VW-1:0] r;
        logic [VW-1:0] g;
        logic [VW-1:0] b;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    i_Pattern;
    logic          o_HSync, o_VSync, o_Frame_Start;
    logic [VW-1:0] o_Red, o_Grn, o_Blu;
    pix_t          act_px;

    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    // model state
    int   m_k;
    logic [2:0] m_pat;
    pix_t exp_px;
    int   shown_col = -1;
    int   shown_row = -1;

    vga_pattern_gen #(
        .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
        .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR)
    ) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Pattern(i_Pattern),
        .o_HSync(o_HSync), .o_VSync(o_VSync),
        .o_Red_Video(o_Red), .o_Grn_Video(o_Grn), .o_Blu_Video(o_Blu),
        .o_Frame_Start(o_Frame_Start)
    );

    assign act_px = {o_HSync, o_VSync, o_Frame_Start, o_Red, o_Grn, o_Blu};

    always #5 clk = ~clk;

    // Reference pixel straight from the pattern definitions
    function automatic pix_t ref_pixel(input int pat, input int c, input int r, input bit first);
        pix_t p;
        int   bar;
        p    = '0;
        p.fs = first;
        p.hs = (c < AC);
        p.vs = (r < AR);
        if (p.hs && p.vs) begin
            case (pat)
                1: p.r = FULL;
                2: p.g = FULL;
                3: p.b = FULL;
                4: if (((c / 32) + (r / 32)) % 2 == 1) begin p.r = FULL; p.g = FULL; p.b = FULL; end
                5: begin
                    bar = c / (AC / 8);
                    p.r = (bar >= 4) ? FULL : '0;
                    p.g = (((bar / 2) % 2) == 1) ? FULL : '0;
                    p.b = ((bar % 2) == 1) ? FULL : '0;
                end
                6: if (c == 0 || c == AC - 1 || r == 0 || r == AR - 1) begin
                    p.r = FULL; p.g = FULL; p.b = FULL;
                end
                7: begin
                    p.r = VW'(c >> (10 - VW));
                    p.g = p.r;
                    p.b = p.r;
                end
                default: ;
            endcase
        end
        return p;
    endfunction

    function automatic pix_t mk(input logic hs, input logic vs, input logic fs,
                                input int r, input int g, input int b);
        pix_t p;
        p = {hs, vs, fs, VW'(r), VW'(g), VW'(b)};
        return p;
    endfunction

    task automatic check(input string name, input pix_t exp);
        checks++;
        if (act_px !== exp) begin
            errors++;
            $display("FAIL %s: got hs=%0b vs=%0b fs=%0b rgb=%0d/%0d/%0d, expected hs=%0b vs=%0b fs=%0b rgb=%0d/%0d/%0d (t=%0t)",
                     name, act_px.hs, act_px.vs, act_px.fs, act_px.r, act_px.g, act_px.b,
                     exp.hs, exp.vs, exp.fs, exp.r, exp.g, exp.b, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_pixel(input int c, input int r);
        int budget;
        bit found;
        budget = F + 4;
        found  = 0;
        while (!found && budget > 0) begin
            @(negedge clk);
            budget--;
            if (shown_col == c && shown_row == r) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_pixel: (%0d,%0d) not shown within %0d cycles", c, r, F + 4);
        end
    endtask

    task automatic wait_frame();
        int budget;
        bit found;
        budget = 2 * F;
        found  = 0;
        while (!found && budget > 0) begin
            @(negedge clk);
            budget--;
            if (o_Frame_Start === 1'b1) found = 1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL wait_frame: no frame start within %0d cycles", 2 * F);
        end
    endtask

    task automatic add(input int p, input int c, input int r, input logic hs, input logic vs,
                       input int rr, input int gg, input int bb);
        vec_t v;
        v.pat = 3'(p); v.col = c; v.row = r; v.hs = hs; v.vs = vs;
        v.r = VW'(rr); v.g = VW'(gg); v.b = VW'(bb);
        tbl.push_back(v);
    endtask

    // Reference model: raster position and frame pattern from elapsed pixels
    initial begin
        m_k    = 0;
        m_pat  = 3'd0;
        exp_px = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_k = 0; m_pat = 3'd0; exp_px = '0;
                shown_col = -1; shown_row = -1;
            end else begin
                shown_col = m_k % TC;
                shown_row = m_k / TC;
                exp_px    = ref_pixel(int'(m_pat), shown_col, shown_row, m_k == 0);
                if (m_k == F - 1) begin
                    m_pat = i_Pattern;
                    m_k   = 0;
                end else begin
                    m_k++;
                end
            end
        end
    end

    // Random-sampled scoreboard against the model
    initial begin
        forever begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) check("scoreboard", exp_px);
        end
    end

    // Frame period and sync duty per frame
    initial begin
        int  fm_cyc, fm_hs, fm_vs;
        bit  fm_have;
        fm_have = 0; fm_cyc = 0; fm_hs = 0; fm_vs = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fm_have = 0;
            end else if (o_Frame_Start) begin
                if (fm_have) begin
                    check_int("frame_period", fm_cyc, F);
                    check_int("hsync_high_per_frame", fm_hs, AC * TR);
                    check_int("vsync_high_per_frame", fm_vs, AR * TC);
                end
                fm_have = 1;
                fm_cyc  = 1;
                fm_hs   = int'(o_HSync);
                fm_vs   = int'(o_VSync);
            end else if (fm_have) begin
                fm_cyc++;
                fm_hs += int'(o_HSync);
                fm_vs += int'(o_VSync);
            end
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] active_pat;

        // {pattern, col, row, hs, vs, r, g, b} in raster order per pattern
        add(1, 80,  5, 0, 1,  0,  0,  0);
        add(1, 79, 35, 1, 1, 63,  0,  0);
        add(1,  0, 36, 1, 0,  0,  0,  0);
        add(2, 10, 10, 1, 1,  0, 63,  0);
        add(3, 10, 10, 1, 1,  0,  0, 63);
        add(5,  0, 10, 1, 1,  0,  0,  0);
        add(5,  9, 10, 1, 1,  0,  0,  0);
        add(5, 10, 10, 1, 1,  0,  0, 63);
        add(5, 35, 10, 1, 1,  0, 63, 63);
        add(5, 45, 10, 1, 1, 63,  0,  0);
        add(5, 65, 10, 1, 1, 63, 63,  0);
        add(5, 79, 10, 1, 1, 63, 63, 63);
        add(5, 80, 10, 0, 1,  0,  0,  0);
        add(5, 99, 10, 0, 1,  0,  0,  0);
        add(4, 31,  0, 1, 1,  0,  0,  0);
        add(4, 32,  0, 1, 1, 63, 63, 63);
        add(4,  0, 32, 1, 1, 63, 63, 63);
        add(4, 32, 32, 1, 1,  0,  0,  0);
        add(4, 79, 35, 1, 1, 63, 63, 63);
        add(6, 40,  0, 1, 1, 63, 63, 63);
        add(6,  1,  1, 1, 1,  0,  0,  0);
        add(6,  0, 10, 1, 1, 63, 63, 63);
        add(6, 40, 10, 1, 1,  0,  0,  0);
        add(6, 79, 10, 1, 1, 63, 63, 63);
        add(6, 40, 35, 1, 1, 63, 63, 63);
        add(6, 40, 36, 1, 0,  0,  0,  0);
        add(7,  0,  5, 1, 1,  0,  0,  0);
        add(7, 15,  5, 1, 1,  0,  0,  0);
        add(7, 16,  5, 1, 1,  1,  1,  1);
        add(7, 50,  5, 1, 1,  3,  3,  3);
        add(7, 79,  5, 1, 1,  4,  4,  4);
        add(7, 80,  5, 0, 1,  0,  0,  0);

        // Reset state and first pixel after release
        rst_n     = 1'b1;
        i_Pattern = 3'd0;
        #1 rst_n  = 1'b0;
        #2 check("reset_state", '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_pixel_origin", mk(1, 1, 1, 0, 0, 0));

        // Pattern change mid-frame must wait for the next frame
        wait_pixel(10, 20);
        i_Pattern = 3'd1;
        wait_pixel(10, 25);
        check("midframe_still_black_a", mk(1, 1, 0, 0, 0, 0));
        wait_pixel(50, 35);
        check("midframe_still_black_b", mk(1, 1, 0, 0, 0, 0));
        wait_frame();
        check("next_frame_red_origin", mk(1, 1, 1, 63, 0, 0));
        active_pat = 3'd1;

        // Table-driven pattern vectors
        foreach (tbl[i]) begin
            if (tbl[i].pat != active_pat) begin
                i_Pattern = tbl[i].pat;
                wait_frame();
                active_pat = tbl[i].pat;
            end
            wait_pixel(tbl[i].col, tbl[i].row);
            check($sformatf("vec%0d_p%0d_(%0d,%0d)", i, tbl[i].pat, tbl[i].col, tbl[i].row),
                  mk(tbl[i].hs, tbl[i].vs, 1'b0, int'(tbl[i].r), int'(tbl[i].g), int'(tbl[i].b)));
        end

        // Asynchronous reset mid-frame, off the clock edge
        i_Pattern = 3'd1;
        wait_frame();
        wait_pixel(40, 30);
        check("pre_reset_red", mk(1, 1, 0, 63, 0, 0));
        #3 rst_n = 1'b0;
        #1 check("reset_async_clear", '0);
        repeat (3) @(posedge clk);
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_reset_origin", mk(1, 1, 1, 0, 0, 0));
        wait_pixel(10, 5);
        check("post_reset_pattern_black", mk(1, 1, 0, 0, 0, 0));
        wait_frame();
        check("post_reset_next_frame_red", mk(1, 1, 1, 63, 0, 0));

        // Randomised pattern requests against the model
        repeat (16000) begin
            @(negedge clk);
            if ($urandom_range(0, 399) == 0) i_Pattern = 3'($urandom_range(0, 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter VIDEO_WIDTH, default 3, bits per colour channel.
REQ-002 SHALL have parameter TOTAL_COLS, default 800, pixel clocks per line including blanking.
REQ-003 SHALL have parameter TOTAL_ROWS, default 525, lines per frame including blanking.
REQ-004 SHALL have parameter ACTIVE_COLS, default 640, visible pixels per line.
REQ-005 SHALL have parameter ACTIVE_ROWS, default 480, visible lines per frame.
REQ-006 SHALL have port i_Clk  input  1  pixel clock; all logic rising-edge.
REQ-007 SHALL have port i_Rst_L  input  1  asynchronous active-low reset.
REQ-008 SHALL have port i_Pattern  input  3  requested pattern select.
REQ-009 SHALL have port o_HSync  output  1  raw line sync, high during active columns.
REQ-010 SHALL have port o_VSync  output  1  raw frame sync, high during active rows.
REQ-011 SHALL have ports o_Red_Video, o_Grn_Video, o_Blu_Video  output  VIDEO_WIDTH each  pixel colour.
REQ-012 SHALL have port o_Frame_Start  output  1  one-cycle pulse with pixel (0,0).

Function
REQ-013 SHALL keep 10-bit column counter 0..TOTAL_COLS-1; wraps to 0 after TOTAL_COLS-1.
REQ-014 SHALL keep 10-bit row counter 0..TOTAL_ROWS-1; increments only on column wrap; wraps to 0 after TOTAL_ROWS-1.
REQ-015 SHALL register every output from the current counter values: outputs seen after edge N describe the (col,row) held before edge N (1 cycle latency).
REQ-016 SHALL drive o_HSync=1 iff col<ACTIVE_COLS, o_VSync=1 iff row<ACTIVE_ROWS; no porches (added downstream).
REQ-017 SHALL drive all colour outputs to 0 whenever col>=ACTIVE_COLS or row>=ACTIVE_ROWS.
REQ-018 SHALL hold an active-pattern register, loaded from i_Pattern only when col==TOTAL_COLS-1 and row==TOTAL_ROWS-1; i_Pattern changes at other times SHALL NOT affect the current frame.
REQ-019 SHALL use the newly loaded pattern starting at pixel (0,0) of the next frame; no partial frames.
REQ-020 SHALL, inside active area, produce per active pattern (FULL = all ones):
 - 0 black: R=G=B=0.
 - 1 red: R=FULL, G=B=0. 2 green: G=FULL only. 3 blue: B=FULL only.
 - 4 checkerboard: col[5]^row[5] ? all FULL : all 0 (32x32 squares).
 - 5 colour bars: bar=col/(ACTIVE_COLS/8), 0..7; R=FULL iff bar[2], G=FULL iff bar[1], B=FULL iff bar[0].
 - 6 border: all FULL when col==0, col==ACTIVE_COLS-1, row==0 or row==ACTIVE_ROWS-1; else 0.
 - 7 gradient: R=G=B=col[9:10-VIDEO_WIDTH].
REQ-021 SHALL compute bar index without a runtime divider (compare/threshold counter or constant division only).
REQ-022 SHALL assert o_Frame_Start for exactly one cycle, coincident with outputs for (0,0); never otherwise.
REQ-023 SHALL be synthesisable for any TOTAL_COLS, TOTAL_ROWS <= 1024 with ACTIVE <= TOTAL.

Reset
REQ-024 SHALL, while i_Rst_L=0, force col=0, row=0, active pattern=0 and all outputs 0, independent of i_Clk.
REQ-025 SHALL, on first rising edge after i_Rst_L release, present (0,0) outputs: o_HSync=1, o_VSync=1, o_Frame_Start=1, colour from pattern 0.
REQ-026 SHALL, on reset asserted mid-frame, abandon the frame immediately; no residual pattern or sync state survives.

Verification
REQ-027 Reset release, i_Pattern=0, run 2 frames -> o_Frame_Start period exactly 800*525=420000 cycles; o_HSync high 640 of every 800 cycles; o_VSync high 480*800 cycles per frame.
REQ-028 i_Pattern=5 before first frame end -> second frame, row 10: col 0..79 RGB=0/0/0, col 80..159 B=7, col 560..639 RGB=7/7/7, col 640..799 all 0.
REQ-029 i_Pattern 0->1 at mid-frame (row 200) -> remainder of frame black; next frame from (0,0) R=7, G=B=0.
REQ-030 i_Pattern=4 -> (31,0)=0, (32,0)=7 all channels, (32,32)=0, (0,32)=7.
REQ-031 i_Pattern=6, VIDEO_WIDTH=3 -> (0,100)=7, (639,100)=7, (320,0)=7, (320,479)=7, (320,100)=0.
REQ-032 Assert i_Rst_L=0 at row 300 col 400 for 3 cycles, not edge-aligned -> outputs 0 immediately; after release o_Frame_Start on first edge, pattern reverts to 0.
